aes_op_sequencer: RTL and testbench

- Instruction-side generator for the vector AES datapath: the encoder counterpart of the opcode decoder.
- On a start pulse, emits the full 5-bit opcode stream for one AES block encryption: load, initial key add, N rounds, store.
- Sits ahead of the decode stage as an alternate instruction source when the core runs in hardware-sequenced mode.
- Uses a valid/ready handshake toward the pipeline; the pipeline stalls it via op_ready.

---
 rtl/aes_op_sequencer.sv | 91 +++++++++
 tb/tb_aes_op_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/aes_op_sequencer.sv
// aes_op_sequencer: emits the opcode stream for one AES block encryption (vldr, vldr, ARK, N rounds, vstr) over a valid/ready handshake; ports clk, reset, start, abort, num_rounds, op_ready -> opCode, op_valid, busy, done, round_idx; optional nop gaps after compute ops under VECTOR_NOP_GAP_EN
module aes_op_sequencer #(
  parameter int MAX_ROUNDS = 14,
  parameter int NOP_GAP = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] num_rounds,
  input  logic       op_ready,
  output logic [4:0] opCode,
  output logic       op_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] round_idx
);
  typedef enum logic [3:0] {
    S_IDLE, S_LD_STATE, S_LD_KEY, S_INIT_ARK, S_RK, S_SB, S_SR, S_MC, S_ARK, S_STORE, S_FIN, S_GAP
  } state_t;
  state_t state, nxt, seq;
  logic [3:0] nl;
  logic acc;
  assign acc = op_valid && op_ready;
  if (NOP_GAP < 1 || NOP_GAP > 3 || MAX_ROUNDS < 1 || MAX_ROUNDS > 15) begin : g_bad_param
    $error("aes_op_sequencer: parameter out of range");
  end
`ifdef VECTOR_NOP_GAP_EN
  state_t ret;
  logic [1:0] gcnt;
  logic cmp;
  assign cmp = state inside {S_INIT_ARK, S_RK, S_SB, S_SR, S_MC, S_ARK};
  always_ff @(posedge clk)
    if (reset || abort) begin
      ret <= S_IDLE;
      gcnt <= '0;
    end else if (acc && cmp) begin
      ret <= seq;
      gcnt <= '0;
    end else if (acc && state == S_GAP) gcnt <= gcnt + 2'd1;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_IDLE;
      nl <= '0;
      round_idx <= '0;
    end else begin
      state <= nxt;
      if (state == S_IDLE && start) nl <= num_rounds > 4'(MAX_ROUNDS) ? 4'(MAX_ROUNDS) : num_rounds;
      round_idx <= nxt == S_IDLE ? 4'd0 : (acc && nxt == S_RK) ? round_idx + 4'd1 : round_idx;
    end
  always_comb begin
    seq = S_IDLE;
    case (state)
      S_IDLE:     seq = start ? S_LD_STATE : S_IDLE;
      S_LD_STATE: seq = S_LD_KEY;
      S_LD_KEY:   seq = S_INIT_ARK;
      S_INIT_ARK: seq = nl == 4'd0 ? S_STORE : S_RK;
      S_RK:       seq = S_SB;
      S_SB:       seq = S_SR;
      S_SR:       seq = round_idx == nl ? S_ARK : S_MC;
      S_MC:       seq = S_ARK;
      S_ARK:      seq = round_idx < nl ? S_RK : S_STORE;
      S_STORE:    seq = S_FIN;
`ifdef VECTOR_NOP_GAP_EN
      S_GAP:      seq = gcnt == 2'(NOP_GAP - 1) ? ret : S_GAP;
`endif
      default:    seq = S_IDLE;
    endcase
    nxt = abort ? S_IDLE : (state == S_IDLE || state == S_FIN || acc) ? seq : state;
`ifdef VECTOR_NOP_GAP_EN
    if (!abort && acc && cmp) nxt = S_GAP;
`endif
  end
  always_comb begin
    opCode = 5'b00000;
    case (state)
      S_LD_STATE, S_LD_KEY: opCode = 5'b10010;
      S_INIT_ARK, S_ARK:    opCode = 5'b10011;
      S_RK:                 opCode = 5'b11001;
      S_SB:                 opCode = 5'b11000;
      S_SR:                 opCode = 5'b10100;
      S_MC:                 opCode = 5'b10101;
      S_STORE:              opCode = 5'b10001;
      default:              opCode = 5'b00000;
    endcase
    op_valid = !(state inside {S_IDLE, S_FIN});
    busy = op_valid;
    done = state == S_FIN;
  end
endmodule

// File: tb/tb_aes_op_sequencer.sv
// tb_aes_op_sequencer: table-driven self-checking bench for aes_op_sequencer
module tb_aes_op_sequencer;
  localparam logic [4:0] NOP = 5'b00000, VSTR = 5'b10001, VLDR = 5'b10010, ARK = 5'b10011;
  localparam logic [4:0] SR = 5'b10100, MC = 5'b10101, SB = 5'b11000, RK = 5'b11001;
  logic clk = 0, reset = 1, start = 1, abort = 0, op_ready = 1;
  logic [3:0] num_rounds = 0;
  logic [4:0] opCode;
  logic op_valid, busy, done;
  logic [3:0] round_idx;
  int pass = 0, total = 0, dn_cnt = 0;
  int peak = 0;
  logic [4:0] got[$], exp_q[$];
  logic vstr_acc_q = 0, stall_q = 0;
  logic [4:0] op_q = 0;
  logic [3:0] ri_q = 0;
  typedef struct {
    logic [3:0] nr;
    bit rnd;
    bit hold;
    int ops;
    int pk;
  } vec_t;
  vec_t vt[6];
  aes_op_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .num_rounds(num_rounds),
    .op_ready(op_ready), .opCode(opCode), .op_valid(op_valid), .busy(busy), .done(done),
    .round_idx(round_idx)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
  endtask
  always @(negedge clk) begin
    chk("done_after_vstr", 32'(done), 32'(vstr_acc_q));
    if (stall_q) begin
      chk("stall_opcode", 32'(opCode), 32'(op_q));
      chk("stall_valid", 32'(op_valid), 1);
      chk("stall_round", 32'(round_idx), 32'(ri_q));
    end
    if (op_valid && op_ready && !abort && !reset) got.push_back(opCode);
    if (int'(round_idx) > peak) peak = int'(round_idx);
    if (done) dn_cnt++;
    vstr_acc_q = op_valid && op_ready && opCode == VSTR && !abort && !reset;
    stall_q = op_valid && !op_ready && !abort && !reset;
    op_q = opCode;
    ri_q = round_idx;
  end
  task automatic push(input logic [4:0] op, input bit c);
    exp_q.push_back(op);
`ifdef VECTOR_NOP_GAP_EN
    if (c) repeat (2) exp_q.push_back(NOP);
`else
    if (c) exp_q.push_back(op) ; if (c) void'(exp_q.pop_back());
`endif
  endtask
  task automatic run(input vec_t v);
    int n, cyc, d0;
    bit eq;
    n = v.nr > 4'd14 ? 14 : int'(v.nr);
    exp_q.delete();
    push(VLDR, 0); push(VLDR, 0); push(ARK, 1);
    for (int r = 1; r <= n; r++) begin
      push(RK, 1); push(SB, 1); push(SR, 1);
      if (r < n) push(MC, 1);
      push(ARK, 1);
    end
    push(VSTR, 0);
    @(posedge clk); #1;
    num_rounds = v.nr; start = 1; op_ready = 1;
    got.delete(); peak = 0; d0 = dn_cnt;
    @(posedge clk); #1;
    if (!v.hold) start = 0;
    num_rounds = 4'd3;
    @(negedge clk);
    chk("first_valid", 32'(op_valid), 1);
    chk("first_opcode", 32'(opCode), 32'(VLDR));
    chk("first_busy", 32'(busy), 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      op_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    op_ready = 1;
    chk("timeout", 32'(cyc < 3000), 1);
    chk("op_count", 32'(got.size()), 32'(v.ops));
    eq = got.size() == exp_q.size();
    if (eq) foreach (got[i]) if (got[i] !== exp_q[i]) eq = 0;
    chk("stream", 32'(eq), 1);
    chk("peak_round", 32'(peak), 32'(v.pk));
    @(negedge clk);
    chk("post_fin_busy", 32'(busy), 0);
    chk("post_fin_valid", 32'(op_valid), 0);
    repeat (3) @(negedge clk);
    chk("done_once", 32'(dn_cnt - d0), 1);
  endtask
  initial begin
`ifdef VECTOR_NOP_GAP_EN
    vt[0] = '{4'd1, 0, 0, 18, 1};
    vt[1] = '{4'd10, 0, 0, 153, 10};
    vt[2] = '{4'd0, 0, 0, 6, 0};
    vt[3] = '{4'd15, 0, 0, 213, 14};
    vt[4] = '{4'd2, 1, 1, 33, 2};
    vt[5] = '{4'd14, 1, 0, 213, 14};
`else
    vt[0] = '{4'd10, 0, 0, 53, 10};
    vt[1] = '{4'd0, 0, 0, 4, 0};
    vt[2] = '{4'd15, 0, 0, 73, 14};
    vt[3] = '{4'd2, 1, 1, 13, 2};
    vt[4] = '{4'd1, 0, 0, 8, 1};
    vt[5] = '{4'd14, 1, 0, 73, 14};
`endif
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", 32'(op_valid), 0);
      chk("rst_opcode", 32'(opCode), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_round", 32'(round_idx), 0);
    end
    @(posedge clk); #1;
    reset = 0; start = 0;
    foreach (vt[i]) run(vt[i]);
    @(posedge clk); #1;
    start = 1; abort = 1;
    @(posedge clk); #1;
    start = 0; abort = 0;
    @(negedge clk);
    chk("start_abort_busy", 32'(busy), 0);
    chk("start_abort_valid", 32'(op_valid), 0);
    begin
      int cyc, d0;
      @(posedge clk); #1;
      num_rounds = 4'd5; start = 1; op_ready = 1; d0 = dn_cnt;
      @(posedge clk); #1;
      start = 0;
      cyc = 0;
      @(negedge clk);
      while (!(round_idx == 4'd3 && opCode == SB) && cyc < 500) begin
        @(negedge clk);
        cyc++;
      end
      chk("abort_reach", 32'(cyc < 500), 1);
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      @(negedge clk);
      chk("abort_valid", 32'(op_valid), 0);
      chk("abort_opcode", 32'(opCode), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_round", 32'(round_idx), 0);
      repeat (4) @(negedge clk);
      chk("abort_no_done", 32'(dn_cnt - d0), 0);
    end
    run(vt[0]);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
